// File: rtl/queen_solver_ctrl_if.sv
// Host-side handshake and status bundle of the 8-queen sequencing controller.
// The host drives start/next; the controller drives status, readout and the backtrack count.
interface queen_solver_ctrl_if #(
   parameter int unsigned BT_W = 16
);
   logic            start;
   logic            next;
   logic            busy;
   logic            done;
   logic            no_solution;
   logic            out_valid;
   logic [2:0]      out_row;
   logic [BT_W-1:0] backtracks;

   modport master (
      output start, next,
      input  busy, done, no_solution, out_valid, out_row, backtracks
   );

   modport slave (
      input  start, next,
      output busy, done, no_solution, out_valid, out_row, backtracks
   );
endinterface

// File: rtl/queen_solver_ctrl.sv
// Sequencing FSM for the 8-queen datapath: iterative backtracking search with
// row-by-row solution readout and resume-for-next-solution support.
module queen_solver_ctrl #(
   parameter int unsigned BT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   queen_solver_ctrl_if.slave  host,
   input  logic                cout,
   input  logic                down_counter_zero,
   input  logic                last_queen_counter_zero,
   input  logic                last_cell,
   input  logic                safe,
   output logic                enable_output,
   output logic                shift_right,
   output logic                counter_reset,
   output logic                count_up,
   output logic                count_down,
   output logic                count,
   output logic                load_counter
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_INIT = 4'd1;
   localparam logic [3:0] S_CHK  = 4'd2;
   localparam logic [3:0] S_CMP  = 4'd3;
   localparam logic [3:0] S_ADV  = 4'd4;
   localparam logic [3:0] S_OUT0 = 4'd5;
   localparam logic [3:0] S_OUT  = 4'd6;
   localparam logic [3:0] S_DONE = 4'd7;
   localparam logic [3:0] S_RES  = 4'd8;
   localparam logic [3:0] S_FAIL = 4'd9;

   localparam logic [BT_W-1:0] BT_ONE = {{(BT_W-1){1'b0}}, 1'b1};
   localparam logic [BT_W-1:0] BT_MAX = '1;

   logic [3:0]      state;
   logic [3:0]      state_nxt;
   logic [2:0]      idx;
   logic [BT_W-1:0] bt_q;
   logic            nosol_q;
   logic            wrap_back;
   logic            exhausted;

   // Row wraps from column 7: back up one row, or give up when already at row 0.
   assign wrap_back = (state == S_ADV) && last_cell && !last_queen_counter_zero;
   assign exhausted = (state == S_ADV) && last_cell &&  last_queen_counter_zero;

   always_comb begin
      state_nxt     = state;
      enable_output = 1'b0;
      shift_right   = 1'b0;
      counter_reset = 1'b0;
      count_up      = 1'b0;
      count_down    = 1'b0;
      count         = 1'b0;
      load_counter  = 1'b0;
      case (state)
         S_IDLE, S_FAIL: begin
            if (host.start) state_nxt = S_INIT;
         end
         S_INIT: begin
            counter_reset = 1'b1;
            state_nxt     = S_CHK;
         end
         S_CHK: begin
            if (cout) begin
               state_nxt = S_OUT0;
            end else if (last_queen_counter_zero) begin
               count_up = 1'b1;
            end else begin
               load_counter = 1'b1;
               state_nxt    = S_CMP;
            end
         end
         S_CMP: begin
            if (!safe) begin
               state_nxt = S_ADV;
            end else if (down_counter_zero) begin
               count_up  = 1'b1;
               state_nxt = S_CHK;
            end else begin
               count = 1'b1;
            end
         end
         S_ADV: begin
            shift_right = 1'b1;
            if (!last_cell)                   state_nxt = S_CHK;
            else if (last_queen_counter_zero) state_nxt = S_FAIL;
            else                              count_down = 1'b1;
         end
         S_OUT0: begin
            counter_reset = 1'b1;
            state_nxt     = S_OUT;
         end
         S_OUT: begin
            enable_output = 1'b1;
            count_up      = 1'b1;
            if (idx == 3'd7) state_nxt = S_DONE;
         end
         S_DONE: begin
            if (host.next) state_nxt = S_RES;
         end
         S_RES: begin
            count_down = 1'b1;
            state_nxt  = S_ADV;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         idx     <= '0;
         bt_q    <= '0;
         nosol_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == S_IDLE || state == S_FAIL) && host.start) begin
            bt_q    <= '0;
            nosol_q <= 1'b0;
         end
         if (wrap_back && bt_q != BT_MAX) bt_q <= bt_q + BT_ONE;
         if (exhausted) nosol_q <= 1'b1;
         if (state == S_OUT0) idx <= '0;
         else if (state == S_OUT) idx <= idx + 3'd1;
      end
   end

   assign host.busy        = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
   assign host.done        = (state == S_DONE);
   assign host.no_solution = nosol_q;
   assign host.out_valid   = (state == S_OUT);
   assign host.out_row     = (state == S_OUT) ? idx : 3'd0;
   assign host.backtracks  = bt_q;

endmodule

// File: tb/tb_queen_solver_ctrl.sv
// Bench for queen_solver_ctrl: behavioural datapath around two controller copies
// (BT_W=16 and BT_W=4) checked against a software enumeration of the 8-queen search.
module tb_queen_solver_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic start, next;
   logic force_safe;
   logic proto_on;

   queen_solver_ctrl_if #(.BT_W(16)) hif ();
   queen_solver_ctrl_if #(.BT_W(4))  hif4 ();
   assign hif.start  = start;
   assign hif.next   = next;
   assign hif4.start = start;
   assign hif4.next  = next;

   logic cout, dcz, lqcz, last_cell, safe;
   logic enable_output, shift_right, counter_reset, count_up, count_down, count, load_counter;
   logic enable_output4, shift_right4, counter_reset4, count_up4, count_down4, count4, load_counter4;

   queen_solver_ctrl #(.BT_W(16)) dut (
      .clk(clk), .reset(reset), .host(hif),
      .cout(cout), .down_counter_zero(dcz), .last_queen_counter_zero(lqcz),
      .last_cell(last_cell), .safe(safe),
      .enable_output(enable_output), .shift_right(shift_right), .counter_reset(counter_reset),
      .count_up(count_up), .count_down(count_down), .count(count), .load_counter(load_counter)
   );

   queen_solver_ctrl #(.BT_W(4)) dut4 (
      .clk(clk), .reset(reset), .host(hif4),
      .cout(cout), .down_counter_zero(dcz), .last_queen_counter_zero(lqcz),
      .last_cell(last_cell), .safe(safe),
      .enable_output(enable_output4), .shift_right(shift_right4), .counter_reset(counter_reset4),
      .count_up(count_up4), .count_down(count_down4), .count(count4), .load_counter(load_counter4)
   );

   logic [6:0] strb, strb4;
   assign strb  = {enable_output, shift_right, counter_reset, count_up, count_down, count, load_counter};
   assign strb4 = {enable_output4, shift_right4, counter_reset4, count_up4, count_down4, count4, load_counter4};

   // Behavioural datapath: queen column per row, row counter, other-queen counter.
   logic [2:0] col [8];
   logic [3:0] row;
   logic [2:0] dn;
   logic [2:0] cur_col, oth_col, dcol, drow;
   logic [7:0] out_bus;

   always_comb begin
      cur_col   = col[row[2:0]];
      oth_col   = col[dn];
      cout      = row[3];
      lqcz      = (row == 4'd0);
      dcz       = (dn == 3'd0);
      last_cell = (cur_col == 3'd7);
      dcol      = (cur_col > oth_col) ? cur_col - oth_col : oth_col - cur_col;
      drow      = row[2:0] - dn;
      safe      = force_safe || ((cur_col != oth_col) && (dcol != drow));
   end
   assign out_bus = enable_output ? (8'd1 << cur_col) : 8'bz;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) col[i] <= 3'd0;
         row <= 4'd0;
         dn  <= 3'd0;
      end else begin
         if (counter_reset)   row <= 4'd0;
         else if (count_up)   row <= row + 4'd1;
         else if (count_down) row <= row - 4'd1;
         if (load_counter)    dn <= row[2:0] - 3'd1;
         else if (count)      dn <= dn - 3'd1;
         if (shift_right)     col[row[2:0]] <= col[row[2:0]] + 3'd1;
      end
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && proto_on) begin
         check("strobe_exclusive", 32'($countones({count_up, count_down, counter_reset}) <= 1), 32'd1);
         check("enable_implies_valid", 32'(!enable_output || hif.out_valid), 32'd1);
         check("bt4_lockstep", {hif4.busy, hif4.done, hif4.no_solution, hif4.out_valid, hif4.out_row, strb4},
               {hif.busy, hif.done, hif.no_solution, hif.out_valid, hif.out_row, strb});
      end
   end

   // Software reference: lexicographic backtracking; one backtrack per exhausted row >= 1.
   int ref_sol [92][8];
   int ref_bt  [92];
   int ref_nsol;
   int ref_bt_total;

   task automatic build_ref();
      int c [8];
      int r, bt;
      bit ok;
      r = 0; bt = 0; ref_nsol = 0; c[0] = 0;
      while (1) begin
         if (c[r] == 8) begin
            if (r == 0) break;
            bt++; r--; c[r]++;
            continue;
         end
         ok = 1;
         for (int k = 0; k < r; k++) begin
            if (c[k] == c[r] || c[k] - c[r] == r - k || c[r] - c[k] == r - k) ok = 0;
         end
         if (!ok) c[r]++;
         else if (r == 7) begin
            for (int k = 0; k < 8; k++) ref_sol[ref_nsol][k] = c[k];
            ref_bt[ref_nsol] = bt;
            ref_nsol++;
            c[r]++;
         end else begin
            r++; c[r] = 0;
         end
      end
      ref_bt_total = bt;
   endtask

   logic [7:0] got [8];

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_next();
      next = 1'b1; tick(); next = 1'b0;
   endtask

   task automatic run_readout(output int nval, output int cu);
      int cyc;
      nval = 0; cu = 0; cyc = 0;
      for (int k = 0; k < 8; k++) got[k] = 8'h00;
      while (!hif.done && !hif.no_solution && cyc < 40000) begin
         if (hif.out_valid) begin
            check("out_row_order", 32'(hif.out_row), nval);
            if (nval < 8) got[nval] = out_bus;
            nval++;
         end else if (count_up) cu++;
         tick();
         cyc++;
      end
      check("wait_bound", 32'(cyc < 40000), 32'd1);
   endtask

   int nval, cu, exp4;

   initial begin
      build_ref();
      reset = 1'b0; start = 1'b0; next = 1'b0; force_safe = 1'b0; proto_on = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      tick();
      check("rst_busy", 32'(hif.busy), 0);
      check("rst_done", 32'(hif.done), 0);
      check("rst_nosol", 32'(hif.no_solution), 0);
      check("rst_valid", 32'(hif.out_valid), 0);
      check("rst_row", 32'(hif.out_row), 0);
      check("rst_bt", 32'(hif.backtracks), 0);
      check("rst_strobes", 32'(strb), 0);

      pulse_next(); tick();
      check("next_in_idle", 32'(hif.busy), 0);

      // Reset while comparing: controller drops straight back to idle.
      pulse_start();
      for (int n = 0; n < 100 && !load_counter; n++) tick();
      check("reach_cmp", 32'(load_counter), 1);
      tick();
      #2 reset = 1'b0;
      #1;
      check("rst_cmp_strobes", 32'(strb), 0);
      check("rst_cmp_busy", 32'(hif.busy), 0);
      tick(); tick();
      reset = 1'b1;
      tick();

      // Always-safe flags: straight descent, all queens in column 0.
      force_safe = 1'b1;
      pulse_start();
      run_readout(nval, cu);
      check("stub_valid_cnt", nval, 8);
      check("stub_passes", cu, 8);
      check("stub_bt", 32'(hif.backtracks), 0);
      check("stub_done", 32'(hif.done), 1);
      for (int k = 0; k < 8; k++) check("stub_col", 32'(got[k]), 32'h1);
      reset = 1'b0; tick(); reset = 1'b1; force_safe = 1'b0; tick();

      // Full search, all solutions in order.
      pulse_start();
      for (int s = 0; s < 92; s++) begin
         run_readout(nval, cu);
         check("sol_valid_cnt", nval, 8);
         check("sol_done", 32'(hif.done), 1);
         check("sol_busy", 32'(hif.busy), 0);
         for (int k = 0; k < 8; k++) check("sol_col", 32'(got[k]), 32'(8'd1 << ref_sol[s][k]));
         check("sol_bt", 32'(hif.backtracks), ref_bt[s]);
         exp4 = (ref_bt[s] > 15) ? 15 : ref_bt[s];
         check("sol_bt4", 32'(hif4.backtracks), exp4);
         if (s == 0) begin
            pulse_start(); tick();
            check("start_in_done", 32'(hif.done), 1);
            check("start_in_done_bt", 32'(hif.backtracks), ref_bt[0]);
         end
         pulse_next();
      end
      run_readout(nval, cu);
      check("end_valid_cnt", nval, 0);
      check("end_nosol", 32'(hif.no_solution), 1);
      check("end_done", 32'(hif.done), 0);
      check("end_busy", 32'(hif.busy), 0);
      check("end_bt", 32'(hif.backtracks), ref_bt_total);
      check("end_bt4", 32'(hif4.backtracks), 15);
      for (int k = 0; k < 8; k++) check("end_col_zero", 32'(col[k]), 0);
      pulse_next(); tick();
      check("next_in_fail", 32'(hif.no_solution), 1);

      pulse_start();
      check("restart_bt", 32'(hif.backtracks), 0);
      check("restart_bt4", 32'(hif4.backtracks), 0);
      check("restart_nosol", 32'(hif.no_solution), 0);
      check("restart_busy", 32'(hif.busy), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
